serial_detect_arbiter: RTL and testbench
========================================

# serial_detect_arbiter

Time-multiplexed 10110 sequence-detection engine shared by `N_CH` serial requesters. Each cycle a round-robin arbiter grants one requesting channel. The single shared Moore 10110 next-state function consumes that channel's bit and updates that channel's saved state; non-granted channels hold state. The block sits in front of the serial-pattern datapath and replaces one detector instance per stream.

## Interface

Parameters:
- `N_CH`, 4: number of serial channels; must be ≥ 2.
- `CNT_W`, 8: width of each per-channel match counter.

Ports (`PW` = $clog2(`N_CH`)):
- `clock`  in  1  single clock, posedge.
- `reset`  in  1  synchronous reset, active-high.
- `req`  in  `N_CH`  channel i holds a bit for consumption; held until granted.
- `j`  in  `N_CH`  serial data bit of channel i; valid while `req[i]`=1.
- `clr`  in  `N_CH`  synchronous per-channel clear of state and counter.
- `grant`  out  `N_CH`  one-hot or zero, combinational; `j[i]` consumed at this posedge.
- `w`  out  `N_CH`  Moore output: channel i saved state == S5.
- `hit_valid`  out  1  registered one-cycle pulse: the previous grant moved its channel into S5.
- `hit_chan`  out  `PW`  channel of that hit; holds its last value when `hit_valid`=0.
- `match_cnt`  out  `N_CH`×`CNT_W`  packed per-channel saturating match counters.

## Operation

- Per-channel state register (3 bits) with states:
  - S0: idle
  - S1: seen "1"
  - S2: seen "10"
  - S3: seen "101"
  - S4: seen "1011"
  - S5: seen "10110", detected
- Transitions, written as in0/in1 (overlapping detection):
  - S0→S0/S1
  - S1→S2/S1
  - S2→S0/S3
  - S3→S2/S4
  - S4→S5/S1
  - S5→S0/S3
- Arbiter:
  - `rr_ptr` (`PW` bits) gives the highest-priority channel.
  - The grant goes to the first `req` bit at or after `rr_ptr`, scanning upward with wrap-around.
  - No requests: `grant`=0, `rr_ptr` unchanged.
  - After a grant to channel k: `rr_ptr` ← (k+1) mod `N_CH`.
- Granted channel k at posedge: state[k] ← next(state[k], `j[k]`).
  - If the next state is S5: `match_cnt[k]` increments, saturating at 2^`CNT_W`−1.
  - Also on that posedge: `hit_valid`←1 and `hit_chan`←k.
- `clr[i]`: state[i]←S0 and `match_cnt[i]`←0.
  - `clr` has priority over a same-cycle grant.
  - The arbiter still issues the grant and advances `rr_ptr`, but the bit is discarded and there is no hit.
- Reset: all states S0, all counters 0, `rr_ptr`=0, `hit_valid`=0, `hit_chan`=0. `w`=0, `grant`=0 while `reset`=1.
- Reset mid-stream discards all partial matches; there is no recovery of prior state.

## Timing

- Grant is combinational in the same cycle as `req`. The bit is consumed on that posedge; the requester drops or advances `req`/`j` after seeing `grant[i]`.
- `w[i]` and `hit_valid` rise 1 cycle after the granted edge. This is pure Moore: `w[i]` stays high until channel i's next grant, then falls.
- Throughput: 1 bit per cycle total. With all channels requesting, each is served every `N_CH` cycles.
- A single requester is served every cycle.
- Counters update on the same edge as the state transition into S5.

## Structure

- Shared package `serial_detect_pkg`:
  - `det_state_t` enum (S0..S5, 3-bit).
  - Function `det_next(det_state_t s, logic b)`.
- Sub-module `rr_arbiter #(N)`: inputs `req`, `ptr`; outputs one-hot `grant` and encoded `gidx`.
- State array, counters and the hit register live in the top module.

## Test plan

1. **Reset defaults.** Assert `reset` 2 cycles. Require `grant`=0, `w`=0, all `match_cnt`=0 and `hit_valid`=0 afterwards.
2. **Single channel, overlap.** Channel 0 alone streams 1,0,1,1,0,1,1,0, one bit per cycle.
   - `w[0]` high 1 cycle after the 5th and 8th bits.
   - Two `hit_valid` pulses with `hit_chan`=0.
   - `match_cnt[0]`=2.
3. **Round robin.** All 4 `req` held for 8 cycles. Require `grant` sequence 0001,0010,0100,1000,0001,…
   - Drop `req[1]`: the sequence skips channel 1.
4. **Interleaved independence.**
   - Channel 0 feeds 10110 and channel 2 feeds 10100, both under contention.
   - Only channel 0 hits: `match_cnt[0]`=1, `match_cnt[2]`=0.
   - Channel 2 finishes in S0.
5. **Clear vs grant, and mid-stream reset.**
   - Channel 3 at S4 receives bit 0 with `clr[3]`=1 in the same cycle: no hit, state S0, count 0.
   - Separately, assert `reset` after channel 1 reaches S4, then feed 0: no hit.
6. **Saturation.** With `CNT_W`=2, feed channel 0 "10110" repeated 5 times (overlap gives 5 hits). `match_cnt[0]` stops at 3; `hit_valid` still pulses on every hit.

Source files
------------

// File: rtl/serial_detect_pkg.sv
// Shared types and the Moore 10110 next-state function for the time-multiplexed detector.
package serial_detect_pkg;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } det_state_t;

  // Overlapping detection: S5 continues as if "10" (on 0 -> S0) or "101" (on 1 -> S3).
  function automatic det_state_t det_next(det_state_t s, logic b);
    case (s)
      S0:      return b ? S1 : S0;
      S1:      return b ? S1 : S2;
      S2:      return b ? S3 : S0;
      S3:      return b ? S4 : S2;
      S4:      return b ? S1 : S5;
      S5:      return b ? S3 : S0;
      default: return S0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping upward.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] gidx
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int o = 0; o < N; o++) begin
      idx = PW'((int'(ptr) + o) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

endmodule

// File: rtl/serial_detect_arbiter.sv
// One shared 10110 detector serving N_CH serial channels, one granted bit per cycle.
module serial_detect_arbiter
  import serial_detect_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int CNT_W = 8,
  localparam int PW    = $clog2(N_CH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_CH-1:0]       req,
  input  logic [N_CH-1:0]       j,
  input  logic [N_CH-1:0]       clr,
  output logic [N_CH-1:0]       grant,
  output logic [N_CH-1:0]       w,
  output logic                  hit_valid,
  output logic [PW-1:0]         hit_chan,
  output logic [N_CH*CNT_W-1:0] match_cnt
);

  logic [PW-1:0]                 rr_ptr_q, rr_ptr_d, gidx;
  logic [N_CH-1:0]               req_gated, hit_ch;
  det_state_t                    state_q [N_CH];
  det_state_t                    state_d [N_CH];
  det_state_t                    nxt;
  logic [N_CH-1:0][CNT_W-1:0]    cnt_q, cnt_d;
  logic                          hit_valid_q, hit_valid_d;
  logic [PW-1:0]                 hit_chan_q, hit_chan_d;

  // Gating req keeps grant low for the whole reset cycle, not just after the edge.
  assign req_gated = req & {N_CH{~reset}};

  rr_arbiter #(.N(N_CH)) u_arb (
    .req   (req_gated),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .gidx  (gidx)
  );

  always_comb begin
    hit_ch = '0;
    nxt    = S0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      nxt        = det_next(state_q[i], j[i]);
      // clr wins over a same-cycle grant: the granted bit is simply dropped.
      if (clr[i]) begin
        state_d[i] = S0;
        cnt_d[i]   = '0;
      end else if (grant[i]) begin
        state_d[i] = nxt;
        if (nxt == S5) begin
          hit_ch[i] = 1'b1;
          if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|grant) rr_ptr_d = (gidx == PW'(N_CH - 1)) ? '0 : gidx + 1'b1;
    hit_valid_d = |hit_ch;
    hit_chan_d  = (|hit_ch) ? gidx : hit_chan_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) state_q[i] <= S0;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      hit_valid_q <= 1'b0;
      hit_chan_q  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) state_q[i] <= state_d[i];
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      hit_valid_q <= hit_valid_d;
      hit_chan_q  <= hit_chan_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) w[i] = (state_q[i] == S5) && !reset;
  end

  assign hit_valid = hit_valid_q;
  assign hit_chan  = hit_chan_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_serial_detect_arbiter.sv
// Directed bench with a hit scoreboard for serial_detect_arbiter (main and 2-bit-counter instances).
module tb_serial_detect_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req, j, clr;
  logic [3:0]  grant, w;
  logic        hit_valid;
  logic [1:0]  hit_chan;
  logic [31:0] match_cnt;

  logic [3:0]  req_s, j_s, clr_s;
  logic [3:0]  grant_s, w_s;
  logic        hit_valid_s;
  logic [1:0]  hit_chan_s;
  logic [7:0]  match_cnt_s;

  serial_detect_arbiter #(.N_CH(4), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .req(req), .j(j), .clr(clr),
    .grant(grant), .w(w), .hit_valid(hit_valid), .hit_chan(hit_chan), .match_cnt(match_cnt)
  );

  serial_detect_arbiter #(.N_CH(4), .CNT_W(2)) dut_s (
    .clock(clock), .reset(reset), .req(req_s), .j(j_s), .clr(clr_s),
    .grant(grant_s), .w(w_s), .hit_valid(hit_valid_s), .hit_chan(hit_chan_s), .match_cnt(match_cnt_s)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  int mstate [4];
  int mcnt   [4];
  int mptr, last_chan, hits_seen;
  int hitq [$];
  logic [3:0] egrant, last_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int mnext(input int s, input bit b);
    case (s)
      0: return b ? 1 : 0;
      1: return b ? 1 : 2;
      2: return b ? 3 : 0;
      3: return b ? 4 : 2;
      4: return b ? 1 : 5;
      default: return b ? 3 : 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mstate[i] = 0;
      mcnt[i]   = 0;
    end
    mptr = 0;
    last_chan = 0;
    hitq.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; req = '0; j = '0; clr = '0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One cycle: drive at negedge, check grant, step the model, check registered outputs.
  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic [3:0] c);
    int k;
    logic [31:0] ecnt;
    logic [3:0]  ew;
    @(negedge clock);
    req = r; j = d; clr = c;
    #1;
    egrant = '0;
    k = -1;
    for (int o = 0; o < 4; o++)
      if (k < 0 && r[(mptr + o) % 4]) k = (mptr + o) % 4;
    if (k >= 0) egrant[k] = 1'b1;
    last_grant = grant;
    chk("grant", grant, egrant);
    if (k >= 0) mptr = (k + 1) % 4;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) begin
        mstate[i] = 0;
        mcnt[i]   = 0;
      end else if (i == k) begin
        mstate[i] = mnext(mstate[i], d[i]);
        if (mstate[i] == 5) begin
          if (mcnt[i] < 255) mcnt[i]++;
          hitq.push_back(i);
        end
      end
    end
    @(posedge clock);
    #1;
    chk("hit_valid", hit_valid, hitq.size() != 0);
    if (hitq.size() != 0) begin
      last_chan = hitq.pop_front();
      hits_seen++;
    end
    chk("hit_chan", hit_chan, last_chan);
    for (int i = 0; i < 4; i++) begin
      ew[i] = (mstate[i] == 5);
      ecnt[i*8 +: 8] = mcnt[i][7:0];
    end
    chk("w", w, ew);
    chk("match_cnt", match_cnt, ecnt);
  endtask

  initial begin
    logic [7:0] s_ch0;
    logic [4:0] p0, p2, p_sat;
    logic [3:0] rr_exp [8];
    logic [3:0] rr_skip [6];
    logic [3:0] r, d;
    int i0, i2, hs;

    req_s = '0; j_s = '0; clr_s = '0;
    // 1. reset defaults, with every channel requesting during reset
    reset = 1'b1; req = 4'hF; j = 4'hF; clr = '0;
    @(posedge clock);
    @(negedge clock);
    chk("rst_grant", grant, 4'h0);
    chk("rst_w", w, 4'h0);
    @(posedge clock);
    @(negedge clock);
    chk("rst_grant2", grant, 4'h0);
    reset = 1'b0; req = '0; j = '0;
    #1;
    chk("rst_w2", w, 4'h0);
    chk("rst_cnt", match_cnt, 32'h0);
    chk("rst_hv", hit_valid, 1'b0);
    chk("rst_hc", hit_chan, 2'd0);
    chk("rst_cnt_s", match_cnt_s, 8'h0);
    model_reset();

    // 2. channel 0 alone, overlapping 10110110
    s_ch0 = 8'b10110110;
    hits_seen = 0;
    for (int n = 0; n < 8; n++) begin
      step(4'b0001, {3'b0, s_ch0[7-n]}, 4'b0);
      if (n == 4) chk("w0_after5", w[0], 1'b1);
      if (n == 7) chk("w0_after8", w[0], 1'b1);
    end
    chk("t2_hits", hits_seen, 2);
    chk("t2_cnt0", match_cnt[7:0], 8'd2);

    // 3. round robin from pointer 0, then with channel 1 dropped
    do_reset();
    rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rr_skip = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000};
    for (int n = 0; n < 8; n++) begin
      step(4'hF, 4'($urandom_range(0, 15)), 4'b0);
      chk("rr_seq", last_grant, rr_exp[n]);
    end
    do_reset();
    for (int n = 0; n < 6; n++) begin
      step(4'b1101, 4'($urandom_range(0, 15)), 4'b0);
      chk("rr_skip", last_grant, rr_skip[n]);
    end

    // 4. channels 0 and 2 interleaved under contention
    do_reset();
    p0 = 5'b10110; p2 = 5'b10100; i0 = 0; i2 = 0;
    for (int cyc = 0; cyc < 20 && (i0 < 5 || i2 < 5); cyc++) begin
      r = {1'b0, i2 < 5, 1'b0, i0 < 5};
      d = '0;
      if (i0 < 5) d[0] = p0[4-i0];
      if (i2 < 5) d[2] = p2[4-i2];
      step(r, d, 4'b0);
      if (egrant[0]) i0++;
      if (egrant[2]) i2++;
    end
    chk("t4_done", (i0 == 5) && (i2 == 5), 1'b1);
    chk("t4_cnt0", match_cnt[7:0], 8'd1);
    chk("t4_cnt2", match_cnt[23:16], 8'd0);
    chk("t4_w2", w[2], 1'b0);
    // channel 2 from S0: 1,0,1,1,0 must hit exactly once
    hits_seen = 0;
    for (int n = 0; n < 5; n++) step(4'b0100, {1'b0, p0[4-n], 2'b0}, 4'b0);
    chk("t4_ch2_s0", hits_seen, 1);

    // 5a. clr beats a hit-producing grant on channel 3
    do_reset();
    step(4'b1000, 4'b1000, 4'b0);
    step(4'b1000, 4'b0000, 4'b0);
    step(4'b1000, 4'b1000, 4'b0);
    step(4'b1000, 4'b1000, 4'b0);
    step(4'b1000, 4'b0000, 4'b1000);
    chk("clr_hv", hit_valid, 1'b0);
    chk("clr_cnt3", match_cnt[31:24], 8'd0);
    chk("clr_w3", w[3], 1'b0);
    for (int n = 0; n < 4; n++) step(4'b1000, {n == 1 || n == 2, 3'b0}, 4'b0);

    // 5b. reset after channel 1 reaches S4 discards the partial match
    step(4'b0010, 4'b0010, 4'b0);
    step(4'b0010, 4'b0000, 4'b0);
    step(4'b0010, 4'b0010, 4'b0);
    step(4'b0010, 4'b0010, 4'b0);
    do_reset();
    step(4'b0010, 4'b0000, 4'b0);
    chk("rst_mid_hv", hit_valid, 1'b0);
    chk("rst_mid_w", w, 4'h0);

    // 6. 2-bit counter saturates at 3 while hits keep pulsing
    p_sat = 5'b10110; hs = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clock);
      req_s = 4'b0001; j_s = {3'b0, p_sat[4 - (n % 5)]};
      @(posedge clock);
      #1;
      if (n % 5 == 4) hs++;
      chk("sat_hv", hit_valid_s, n % 5 == 4);
      chk("sat_cnt", match_cnt_s, (hs > 3) ? 8'd3 : 8'(hs));
    end
    chk("sat_final", match_cnt_s[1:0], 2'd3);
    @(negedge clock);
    req_s = '0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
